// File: rtl/mmio_ctrl_v2.sv
// MMIO controller: RAM below a top-of-space window of output registers and synchronised inputs.
// Latency: loads return 1 cycle after acceptance (rd_valid pulse); stores to registers visible next cycle.
// Backpressure: none; a read is dropped when a write is presented the same cycle. Optional MMIO_IRQ_EN adds input-change irq.
module mmio_ctrl_v2 #(
    parameter int                    addr_width  = 10,
    parameter int                    data_width  = 32,
    parameter int                    num_out     = 2,
    parameter int                    num_in      = 2,
    parameter logic [data_width-1:0] out_rst_val = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic                           rd_en,
    input  logic [addr_width-1:0]          addr,
    input  logic [data_width-1:0]          wr_data,
    output logic                           ram_wr_en,
    output logic                           ram_rd_en,
    input  logic [data_width-1:0]          ram_rd_data,
    output logic [data_width-1:0]          rd_data,
    output logic                           rd_valid,
    output logic [num_out*data_width-1:0]  out_ports,
    input  logic [num_in*data_width-1:0]   in_ports,
    output logic                           irq
);

    localparam logic [addr_width-1:0] TOP = '1;

    logic [num_out-1:0]             hit_out;
    logic [num_in-1:0]              hit_in;
    logic                           in_win;
    logic                           rd_acc;
    logic [data_width-1:0]          io_sel;

    logic [num_out*data_width-1:0]  out_q, out_d;
    logic [num_in*data_width-1:0]   sync1_q, sync1_d;
    logic [num_in*data_width-1:0]   sync2_q, sync2_d;
    logic                           rd_vld_q, rd_vld_d;
    logic                           rd_ram_q, rd_ram_d;
    logic [data_width-1:0]          rd_io_q, rd_io_d;
    logic [data_width-1:0]          hold_q, hold_d;

    // Full-width unsigned address decode and selection of the I/O word being read
    always_comb begin
        hit_out = '0;
        hit_in  = '0;
        io_sel  = '0;
        for (int k = 0; k < num_out; k++) begin
            hit_out[k] = (addr == TOP - addr_width'(k));
            if (hit_out[k]) io_sel = out_q[k*data_width +: data_width];
        end
        for (int j = 0; j < num_in; j++) begin
            hit_in[j] = (addr == TOP - addr_width'(num_out + j));
            if (hit_in[j]) io_sel = sync2_q[j*data_width +: data_width];
        end
    end

    assign in_win    = (|hit_out) | (|hit_in);
    // A write in the same cycle always wins over a read
    assign rd_acc    = rd_en & ~wr_en;
    assign ram_wr_en = wr_en & ~in_win;
    assign ram_rd_en = rd_acc & ~in_win;

    // Next-state: register writes, input synchronisers, read-return pipeline, held read data
    always_comb begin
        out_d = out_q;
        for (int k = 0; k < num_out; k++) begin
            if (wr_en && hit_out[k]) out_d[k*data_width +: data_width] = wr_data;
        end
        sync1_d  = in_ports;
        sync2_d  = sync1_q;
        rd_vld_d = rd_acc;
        rd_ram_d = rd_acc & ~in_win;
        rd_io_d  = rd_acc ? io_sel : rd_io_q;
        hold_d   = rd_valid ? rd_data : hold_q;
    end

    // Outputs: a reset in the return cycle suppresses the pending valid
    always_comb begin
        rd_valid  = rd_vld_q & ~rst;
        rd_data   = hold_q;
        if (rd_valid) rd_data = rd_ram_q ? ram_rd_data : rd_io_q;
        out_ports = out_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= {num_out{out_rst_val}};
            sync1_q  <= '0;
            sync2_q  <= '0;
            rd_vld_q <= 1'b0;
            rd_ram_q <= 1'b0;
            rd_io_q  <= '0;
            hold_q   <= '0;
        end else begin
            out_q    <= out_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            rd_vld_q <= rd_vld_d;
            rd_ram_q <= rd_ram_d;
            rd_io_q  <= rd_io_d;
            hold_q   <= hold_d;
        end
    end

`ifdef MMIO_IRQ_EN
    logic [num_in*data_width-1:0]   sync3_q, sync3_d;
    logic [num_in-1:0]              pend_q, pend_d;
    logic                           irq_q, irq_d;

    // Pending bit per input: set on a synchronised change, cleared by a read of that input (set wins)
    always_comb begin
        sync3_d = sync2_q;
        pend_d  = pend_q;
        for (int j = 0; j < num_in; j++) begin
            if (rd_acc && hit_in[j]) pend_d[j] = 1'b0;
            if (sync2_q[j*data_width +: data_width] != sync3_q[j*data_width +: data_width])
                pend_d[j] = 1'b1;
        end
        irq_d = |pend_q;
    end

    // Interrupt state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync3_q <= '0;
            pend_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync3_q <= sync3_d;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_ctrl_v2.sv
module tb_mmio_ctrl_v2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [9:0]  addr;
    logic [31:0] wr_data;
    logic        ram_wr_en;
    logic        ram_rd_en;
    logic [31:0] ram_rd_data;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [63:0] out_ports;
    logic [63:0] in_ports;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    mmio_ctrl_v2 dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wr_data(wr_data), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
        .ram_rd_data(ram_rd_data), .rd_data(rd_data), .rd_valid(rd_valid),
        .out_ports(out_ports), .in_ports(in_ports), .irq(irq)
    );

    // RAM model: synchronous write, 1-cycle read
    always @(posedge clk) begin
        if (ram_wr_en) mem[addr] <= wr_data;
        if (ram_rd_en) ram_rd_data <= mem[addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        ram_rd_data = 32'h0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0; in_ports = '0;
        @(negedge clk);

        // Reset then idle
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_out_ports", out_ports, 64'h0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_ram_wr_en", ram_wr_en, 1'b0);

        // Output register write and readback
        wr_en = 1'b1; addr = 10'h3FF; wr_data = 32'hDEADBEEF;
        #1 chk("out0_wr_no_ram", ram_wr_en, 1'b0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("out0_written", out_ports, {32'h0, 32'hDEADBEEF});
        rd_en = 1'b1; addr = 10'h3FF;
        #1 chk("out0_rd_no_ram", ram_rd_en, 1'b0);
        tick();
        rd_en = 1'b0;
        #1;
        chk("out0_rd_valid", rd_valid, 1'b1);
        chk("out0_rd_data", rd_data, 32'hDEADBEEF);
        tick();
        chk("out0_valid_pulse", rd_valid, 1'b0);
        chk("rd_data_hold", rd_data, 32'hDEADBEEF);

        // RAM path
        wr_en = 1'b1; addr = 10'h010; wr_data = 32'h12345678;
        #1 chk("ram_wr_en", ram_wr_en, 1'b1);
        tick();
        wr_en = 1'b0; rd_en = 1'b1; addr = 10'h010;
        #1 chk("ram_rd_en", ram_rd_en, 1'b1);
        tick();
        rd_en = 1'b0;
        #1;
        chk("ram_rd_valid", rd_valid, 1'b1);
        chk("ram_rd_data", rd_data, 32'h12345678);
        tick();
        chk("ram_one_valid", rd_valid, 1'b0);

        // Back-to-back reads: register then RAM
        rd_en = 1'b1; addr = 10'h3FF;
        tick();
        addr = 10'h010;
        #1;
        chk("b2b_valid0", rd_valid, 1'b1);
        chk("b2b_data0", rd_data, 32'hDEADBEEF);
        tick();
        rd_en = 1'b0;
        #1;
        chk("b2b_valid1", rd_valid, 1'b1);
        chk("b2b_data1", rd_data, 32'h12345678);

        // Input port through synchroniser
        in_ports = {32'h0000A5A5, 32'h0};
        tick(); tick();
        rd_en = 1'b1; addr = 10'h3FC;
        #1 chk("in1_rd_no_ram", ram_rd_en, 1'b0);
        tick();
        addr = 10'h3FD;
        #1 chk("in1_rd_data", rd_data, 32'h0000A5A5);
        tick();
        rd_en = 1'b0;
        #1 chk("in0_rd_data", rd_data, 32'h0);
        wr_en = 1'b1; addr = 10'h3FC; wr_data = 32'hFFFFFFFF;
        #1 chk("in1_wr_no_ram", ram_wr_en, 1'b0);
        tick();
        wr_en = 1'b0;
        #1 chk("in1_wr_ignored", out_ports, {32'h0, 32'hDEADBEEF});

        // Just below the window is RAM
        wr_en = 1'b1; addr = 10'h3FB; wr_data = 32'h0;
        #1 chk("below_window_ram", ram_wr_en, 1'b1);
        wr_en = 1'b0;

        // Write wins over read at the same address
        in_ports = '0;
        wr_en = 1'b1; rd_en = 1'b1; addr = 10'h3FE; wr_data = 32'h7;
        #1 chk("conflict_no_ram_rd", ram_rd_en, 1'b0);
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        #1;
        chk("conflict_no_valid", rd_valid, 1'b0);
        chk("conflict_out1", out_ports, {32'h7, 32'hDEADBEEF});

        // Readback of out1 the cycle after its write
        rd_en = 1'b1; addr = 10'h3FE;
        tick();
        rd_en = 1'b0;
        #1 chk("out1_readback", rd_data, 32'h7);
        tick(); tick();

        // Reset in the return cycle drops the read
        rd_en = 1'b1; addr = 10'h3FF;
        tick();
        rd_en = 1'b0; rst = 1'b1;
        #1 chk("rst_mid_no_valid", rd_valid, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_valid_after", rd_valid, 1'b0);
        chk("rst_mid_out_ports", out_ports, 64'h0);

`ifdef MMIO_IRQ_EN
        // Input change raises irq; reading the input clears it
        in_ports = {32'h0, 32'h1};
        tick(); tick(); tick(); tick();
        chk("irq_set", irq, 1'b1);
        rd_en = 1'b1; addr = 10'h3FD;
        tick();
        rd_en = 1'b0;
        tick();
        chk("irq_cleared", irq, 1'b0);
        chk("irq_in0_data", rd_data, 32'h1);
`else
        // Without the interrupt feature irq never rises
        in_ports = {32'h0, 32'h1};
        tick(); tick(); tick(); tick(); tick();
        chk("irq_disabled", irq, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmio_ctrl_v2.md
Name: mmio_ctrl_v2

Overview:
- Parametrised memory/MMIO controller sitting between the core's load/store path and data RAM plus physical I/O.
- Decodes a window at the top of the address space into N output registers and M input ports.
- Writes to the window update registered outputs and never reach RAM. Reads of the window return I/O data.
- Read data from RAM and from I/O is returned with a uniform 1-cycle latency and a valid strobe.

Parameters:
- addr_width, 10, address bus width
- data_width, 32, data bus and port width
- num_out, 2, number of output registers, 1..32
- num_in, 2, number of input ports, 1..32
- out_rst_val, 0, reset value of every output register

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  store request this cycle
- rd_en  in  1  load request this cycle
- addr  in  addr_width  word address
- wr_data  in  data_width  store data
- ram_wr_en  out  1  combinational: wr_en and addr outside I/O window
- ram_rd_en  out  1  combinational: accepted read and addr outside I/O window
- ram_rd_data  in  data_width  RAM data, valid 1 cycle after ram_rd_en
- rd_data  out  data_width  load result
- rd_valid  out  1  rd_data valid this cycle
- out_ports  out  num_out*data_width  output registers; port k at bits [k*data_width +: data_width]
- in_ports  in  num_in*data_width  asynchronous physical inputs, same packing
- irq  out  1  interrupt request; constant 0 unless MMIO_IRQ_EN

Behaviour:
- Address map, with TOP = 2**addr_width-1:
  - Output k at TOP-k.
  - Input j at TOP-num_out-j.
  - Window = lowest of these through TOP. Everything below the window is RAM.
  - Defaults: out0 = 0x3FF, out1 = 0x3FE, in0 = 0x3FD, in1 = 0x3FC.
- Reset (rst high at clock edge):
  - out_ports = out_rst_val replicated.
  - rd_data = 0, rd_valid = 0, irq = 0.
  - Synchronisers and pending bits cleared.
  - Reset mid-access drops that access: no rd_valid next cycle, no output-register update.
- Write:
  - wr_en with output-k address: out_ports[k] <= wr_data at that edge, visible the next cycle.
  - wr_en with input-port address: ignored, no RAM write.
  - wr_en below the window: ram_wr_en = 1 in the same cycle.
- Input synchronisation:
  - Each in_ports word passes a 2-flop synchroniser.
  - Reads return the synchronised value, so pin-to-readable latency is 2 cycles.
- Read:
  - Accepted when rd_en=1 and wr_en=0.
  - Decode the target (RAM / out k / in j) and register it, along with registered I/O data, at the accept edge.
  - Next cycle: rd_valid = 1, and rd_data = ram_rd_data for a RAM target, otherwise the registered I/O value.
  - Reading out k returns its current register value (readback).
  - rd_valid is a single-cycle pulse per accepted read. Back-to-back reads give back-to-back valids.
  - When no read is returning, rd_data holds its last value.
- Simultaneous wr_en and rd_en: the write wins. The read is dropped: ram_rd_en = 0, and no rd_valid next cycle.
- Same-cycle write to out k and read of out k is impossible, because the read is dropped.
- Read of out k the cycle after a write to it returns the new value.
- Addresses are compared unsigned at full width, so no wrap-around aliasing.

Optional Feature:
- Macro: MMIO_IRQ_EN.
- Defined:
  - Each input port has a pending bit, set when its synchronised value differs from the previous cycle's synchronised value.
  - An accepted read of input j clears pending[j] at the accept edge. If a new change is detected in that same cycle, set wins.
  - irq is registered and equals the OR of the pending bits one cycle later.
- Undefined: no pending logic, irq tied to 0.

Test Plan:
- Reset then idle: rst high 2 cycles → out_ports all 0, rd_valid 0, irq 0, ram_wr_en 0.
- Output write: wr_en, addr 0x3FF, wr_data 0xDEADBEEF → next cycle out_ports[31:0] = 0xDEADBEEF, ram_wr_en stayed 0. Then rd_en 0x3FF → one cycle later rd_valid = 1, rd_data = 0xDEADBEEF.
- RAM path: wr_en addr 0x010 → ram_wr_en = 1 same cycle. rd_en addr 0x010 with the RAM model returning 0x12345678 → next cycle rd_valid = 1, rd_data = 0x12345678, exactly one valid.
- Input port: in_ports[63:32] = 0xA5A5 (in1, addr 0x3FC) → after 2 cycles, rd_en 0x3FC gives rd_data = 0xA5A5 one cycle later. Write to 0x3FC → no change anywhere.
- Conflict and reset: wr_en+rd_en at 0x3FE with data 7 → out1 = 7, no rd_valid. rd_en 0x3FF followed by rst the next cycle → rd_valid stays 0.
- With MMIO_IRQ_EN: toggle in0 from 0 to 1 → irq = 1 within 4 cycles. Read 0x3FD → irq = 0 two cycles later. Without the macro, irq stays 0.
